// File: rtl/pipe_wb_reg.sv
// rtl/pipe_wb_reg.sv - MEM/WB boundary register with write sanitising, stall/bubble/flush control and perf counters
module pipe_wb_reg #(
  parameter int NCH     = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int STALL_W = 6,
  parameter int STAGE   = 4,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [STALL_W-1:0]      stall,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic [NCH-1:0]          in_we,
  input  logic [NCH*ADDR_W-1:0]   in_waddr,
  input  logic [NCH*DATA_W-1:0]   in_wdata,
  input  logic                    in_we_hilo,
  input  logic [DATA_W-1:0]       in_hi,
  input  logic [DATA_W-1:0]       in_lo,
  output logic                    out_valid,
  output logic [NCH-1:0]          out_we,
  output logic [NCH*ADDR_W-1:0]   out_waddr,
  output logic [NCH*DATA_W-1:0]   out_wdata,
  output logic                    out_we_hilo,
  output logic [DATA_W-1:0]       out_hi,
  output logic [DATA_W-1:0]       out_lo,
  output logic                    waw_sticky,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic downstream_stall;
  logic do_bubble;
  logic do_hold;
  logic [NCH-1:0] we_base;
  logic [NCH-1:0] we_san;
  logic waw_hit;
  logic [ADDR_W-1:0] addr_ch [NCH];
  logic unused_stall_bits;

  assign unused_stall_bits = ^stall;

  // The last stage has nothing downstream, so it can never be held by a later stage.
  generate
    if (STAGE + 1 < STALL_W) begin : g_ds
      assign downstream_stall = stall[STAGE+1];
    end else begin : g_no_ds
      assign downstream_stall = 1'b0;
    end
  endgenerate

  assign do_bubble = flush | (stall[STAGE] & ~downstream_stall);
  assign do_hold   = ~flush & stall[STAGE] & downstream_stall;

  always_comb begin
    we_base = '0;
    we_san  = '0;
    waw_hit = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      addr_ch[k] = in_waddr[k*ADDR_W +: ADDR_W];
      we_base[k] = in_we[k] & in_valid & (addr_ch[k] != '0);
    end
    we_san = we_base;
    // Lower channel loses a same-address conflict; its address/data still load.
    for (int j = 0; j < NCH; j++) begin
      for (int k = j + 1; k < NCH; k++) begin
        if (we_base[j] && we_base[k] && (addr_ch[j] == addr_ch[k])) begin
          we_san[j] = 1'b0;
          waw_hit   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_we      <= '0;
      out_waddr   <= '0;
      out_wdata   <= '0;
      out_we_hilo <= 1'b0;
      out_hi      <= '0;
      out_lo      <= '0;
      waw_sticky  <= 1'b0;
      stall_cnt   <= '0;
      bubble_cnt  <= '0;
    end else if (do_bubble) begin
      out_valid   <= 1'b0;
      out_we      <= '0;
      out_waddr   <= '0;
      out_wdata   <= '0;
      out_we_hilo <= 1'b0;
      out_hi      <= '0;
      out_lo      <= '0;
      if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_ONE;
    end else if (do_hold) begin
      if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_ONE;
    end else begin
      out_valid   <= in_valid;
      out_we      <= we_san;
      out_waddr   <= in_waddr;
      out_wdata   <= in_wdata;
      out_we_hilo <= in_we_hilo & in_valid;
      out_hi      <= in_hi;
      out_lo      <= in_lo;
      waw_sticky  <= waw_sticky | waw_hit;
    end
  end

endmodule

// File: doc/pipe_wb_reg.md
Name: pipe_wb_reg

Overview:
- Parametrised MEM/WB pipeline boundary register: NCH register-file write channels plus the HI/LO write, one valid bit.
- Supports stall-hold, bubble insertion and flush.
- Sanitises writes: no writes to register 0; the higher channel wins a same-address conflict.
- Keeps saturating stall and bubble counters for performance monitoring.
- Sits between the memory-access stage and the register file / HI-LO writeback.

Parameters:
- NCH, 2, number of register write channels
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- STALL_W, 6, width of the pipeline stall vector
- STAGE, 4, index of this register's upstream stage in the stall vector; legal range 0 to STALL_W-1
- CNT_W, 16, width of the performance counters

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  STALL_W  per-stage stall vector, 1 = stop
- flush  in  1  discard the incoming entry and insert a bubble
- in_valid  in  1  upstream entry valid
- in_we  in  NCH  per-channel register write enable
- in_waddr  in  NCH*ADDR_W  per-channel write address; channel k occupies bits [k*ADDR_W +: ADDR_W]
- in_wdata  in  NCH*DATA_W  per-channel write data, packed the same way
- in_we_hilo  in  1  HI/LO write enable
- in_hi  in  DATA_W  HI data
- in_lo  in  DATA_W  LO data
- out_valid  out  1  registered entry valid
- out_we  out  NCH  registered, sanitised write enables
- out_waddr  out  NCH*ADDR_W  registered addresses
- out_wdata  out  NCH*DATA_W  registered data
- out_we_hilo  out  1  registered HI/LO enable
- out_hi  out  DATA_W  registered HI
- out_lo  out  DATA_W  registered LO
- waw_sticky  out  1  set when a same-address conflict has been resolved; stays set until reset
- stall_cnt  out  CNT_W  cycles spent holding
- bubble_cnt  out  CNT_W  bubbles inserted

Behaviour:
- Reset: rst_n low asynchronously clears every output and counter to 0, including waw_sticky. This holds regardless of clk and applies mid-stall or mid-flush.
- downstream_stall: stall[STAGE+1] when STAGE+1 < STALL_W, otherwise 0.
- Action at each rising edge, rst_n high, in strict priority:
  1. flush=1 → bubble.
  2. stall[STAGE]=1 and downstream_stall=0 → bubble.
  3. stall[STAGE]=1 and downstream_stall=1 → hold.
  4. Otherwise → load.
- Bubble: out_valid, out_we, out_we_hilo cleared to 0; out_waddr, out_wdata, out_hi, out_lo cleared to 0; bubble_cnt increments.
- Hold: all registered outputs keep their value; stall_cnt increments.
- Load: all outputs take the sanitised inputs. No counter changes.
- Sanitising, applied only on load:
  - Channel k enable = in_we[k] AND in_valid AND (address k != 0).
  - out_we_hilo = in_we_hilo AND in_valid.
  - Same-address conflict: for each pair j < k with both sanitised enables 1 and equal addresses, channel j's enable is cleared and waw_sticky is set.
  - Address and data fields load unmodified even when the enable is cleared.
- in_valid=0 on load: loads with out_valid=0 and all enables 0. This is not counted as a bubble.
- Counters saturate at all-ones and never wrap.
- Flush overrides stall in the same cycle and counts as a bubble, not a stall.
- Latency: one cycle from input to output on load; zero combinational paths from inputs to outputs.

Test Plan:
- Reset mid-hold: drive stall=6'b110000 for 3 cycles, then pull rst_n low between edges → outputs and counters go to 0 immediately, before the next clk edge; stall_cnt had reached 3.
- Load and sanitise: in_valid=1, in_we=2'b11, addr0=5'd0, addr1=5'd7, wdata1=32'hDEADBEEF, in_we_hilo=1, in_hi=32'h1 → next edge out_we=2'b10, out_waddr[1]=7, out_wdata[1]=32'hDEADBEEF, out_we_hilo=1, out_hi=1.
- WAW conflict: both channels addr=5'd9, data0=32'h11, data1=32'h22, in_we=2'b11 → out_we=2'b10, out_wdata[1]=32'h22, waw_sticky=1, and it stays 1 through 10 later clean loads.
- Stall semantics: stall=6'b010000 for 2 cycles → two bubbles, bubble_cnt=2. Then stall=6'b110000 for 4 cycles → outputs frozen, stall_cnt=4.
- Flush priority: flush=1 with stall=6'b110000 → bubble with out_valid=0; bubble_cnt increments, stall_cnt unchanged.
- Saturation: CNT_W=4, hold for 20 cycles → stall_cnt=4'hF and remains 4'hF.
